// File: rtl/zynq_axil_fifo_shell_pkg.sv
// Shared offsets, response codes and FSM/decode enums for the AXI-Lite FIFO shell.
// Optional SLVERR reporting is selected with ZYNQ_AXIL_FIFO_SHELL_SLVERR_EN in the top.
package zynq_axil_fifo_shell_pkg;

  localparam int unsigned CSR_BASE_OFF    = 32'h000;
  localparam int unsigned PS2PL_DATA_OFF  = 32'h100;
  localparam int unsigned PS2PL_FREE_OFF  = 32'h104;
  localparam int unsigned PL2PS_DATA_OFF  = 32'h108;
  localparam int unsigned PL2PS_COUNT_OFF = 32'h10C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_ADDR_DATA, W_RESP} w_state_e;
  typedef enum logic {R_ADDR, R_DATA} r_state_e;

  typedef enum logic [2:0] {
    DEC_CSR,
    DEC_PS2PL_DATA,
    DEC_PS2PL_FREE,
    DEC_PL2PS_DATA,
    DEC_PL2PS_COUNT,
    DEC_NONE
  } addr_dec_e;

endpackage

// File: rtl/zynq_axil_fifo_shell_fifo.sv
// Circular FIFO with occupancy count and a registered head word.
// Push while full is accepted only when a pop happens in the same cycle.
module zynq_axil_fifo_shell_fifo #(
  parameter int unsigned els_p   = 8,
  parameter int unsigned width_p = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    push,
  input  logic                    pop,
  input  logic [width_p-1:0]      wdata,
  output logic [width_p-1:0]      head,
  output logic [$clog2(els_p):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PTR_W = $clog2(els_p);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [width_p-1:0] mem [els_p];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_n;
  logic [CNT_W-1:0]   count_n;
  logic               do_push, do_pop;

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    rd_ptr_n = rd_ptr + PTR_W'(do_pop);
    count_n  = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Head tracks the entry at the post-update read pointer, bypassing a same-cycle write.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      full   <= (count_n == CNT_W'(els_p));
      empty  <= (count_n == '0);
      if (do_push || do_pop)
        head <= (do_push && (wr_ptr == rd_ptr_n)) ? wdata : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/zynq_axil_fifo_shell.sv
// AXI4-Lite slave exposing R/W CSRs plus PS->PL and PL->PS FIFOs with status words.
// Define ZYNQ_AXIL_FIFO_SHELL_SLVERR_EN to report SLVERR on unmapped/illegal accesses.
module zynq_axil_fifo_shell
  import zynq_axil_fifo_shell_pkg::*;
#(
  parameter int unsigned addr_width_p = 10,
  parameter int unsigned data_width_p = 32,
  parameter int unsigned num_csr_p    = 4,
  parameter int unsigned fifo_els_p   = 8
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [addr_width_p-1:0]           s_axil_awaddr,
  input  logic [2:0]                        s_axil_awprot,
  input  logic                              s_axil_awvalid,
  output logic                              s_axil_awready,
  input  logic [data_width_p-1:0]           s_axil_wdata,
  input  logic [3:0]                        s_axil_wstrb,
  input  logic                              s_axil_wvalid,
  output logic                              s_axil_wready,
  output logic [1:0]                        s_axil_bresp,
  output logic                              s_axil_bvalid,
  input  logic                              s_axil_bready,
  input  logic [addr_width_p-1:0]           s_axil_araddr,
  input  logic [2:0]                        s_axil_arprot,
  input  logic                              s_axil_arvalid,
  output logic                              s_axil_arready,
  output logic [data_width_p-1:0]           s_axil_rdata,
  output logic [1:0]                        s_axil_rresp,
  output logic                              s_axil_rvalid,
  input  logic                              s_axil_rready,
  output logic [num_csr_p*data_width_p-1:0] csr_o,
  output logic [data_width_p-1:0]           ps2pl_data_o,
  output logic                              ps2pl_v_o,
  input  logic                              ps2pl_yumi_i,
  input  logic [data_width_p-1:0]           pl2ps_data_i,
  input  logic                              pl2ps_v_i,
  output logic                              ready_and_o
);

`ifdef ZYNQ_AXIL_FIFO_SHELL_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  localparam int unsigned WORD_W = addr_width_p - 2;
  localparam int unsigned CNT_W  = $clog2(fifo_els_p) + 1;
  localparam int unsigned CSR_IW = (num_csr_p > 1) ? $clog2(num_csr_p) : 1;

  function automatic addr_dec_e decode(input logic [WORD_W-1:0] w);
    if (32'(w) - (CSR_BASE_OFF >> 2) < num_csr_p) return DEC_CSR;
    if (w == WORD_W'(PS2PL_DATA_OFF >> 2))  return DEC_PS2PL_DATA;
    if (w == WORD_W'(PS2PL_FREE_OFF >> 2))  return DEC_PS2PL_FREE;
    if (w == WORD_W'(PL2PS_DATA_OFF >> 2))  return DEC_PL2PS_DATA;
    if (w == WORD_W'(PL2PS_COUNT_OFF >> 2)) return DEC_PL2PS_COUNT;
    return DEC_NONE;
  endfunction

  function automatic logic [CSR_IW-1:0] csr_idx(input logic [WORD_W-1:0] w);
    return CSR_IW'(32'(w) - (CSR_BASE_OFF >> 2));
  endfunction

  w_state_e                         w_state;
  r_state_e                         r_state;
  logic                             aw_held, w_held;
  logic [WORD_W-1:0]                awword_q;
  logic [data_width_p-1:0]          wdata_q;
  logic [3:0]                       wstrb_q;
  logic [num_csr_p-1:0][data_width_p-1:0] csr_q;

  logic                             aw_hs_c, w_hs_c, aw_have_c, w_have_c, commit_c;
  logic [WORD_W-1:0]                wword_c, rword_c;
  logic [data_width_p-1:0]          wdata_c, rdata_c;
  logic [3:0]                       wstrb_c;
  addr_dec_e                        wdec_c, rdec_c;
  logic                             werr_c, rerr_c, ps2pl_push_c, ar_hs_c, pl2ps_pop_c;

  logic [CNT_W-1:0]                 ps2pl_count, pl2ps_count;
  logic                             ps2pl_full, ps2pl_empty, pl2ps_full, pl2ps_empty;
  logic [data_width_p-1:0]          pl2ps_head;
  logic                             unused_c;

  assign unused_c = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  // Write channel merge: a channel already held uses its latch, otherwise the live bus.
  always_comb begin
    aw_hs_c      = s_axil_awvalid & s_axil_awready;
    w_hs_c       = s_axil_wvalid & s_axil_wready;
    aw_have_c    = aw_held | aw_hs_c;
    w_have_c     = w_held | w_hs_c;
    wword_c      = aw_held ? awword_q : s_axil_awaddr[addr_width_p-1:2];
    wdata_c      = w_held ? wdata_q : s_axil_wdata;
    wstrb_c      = w_held ? wstrb_q : s_axil_wstrb;
    commit_c     = (w_state == W_ADDR_DATA) & aw_have_c & w_have_c;
    wdec_c       = decode(wword_c);
    ps2pl_push_c = commit_c & (wdec_c == DEC_PS2PL_DATA);
    werr_c       = (wdec_c == DEC_NONE) | (wdec_c == DEC_PS2PL_FREE) |
                   (wdec_c == DEC_PL2PS_COUNT) |
                   ((wdec_c == DEC_PS2PL_DATA) & ps2pl_full & ~ps2pl_yumi_i);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state        <= W_ADDR_DATA;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      awword_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
    end else begin
      case (w_state)
        W_ADDR_DATA: begin
          if (aw_hs_c) begin
            aw_held  <= 1'b1;
            awword_q <= s_axil_awaddr[addr_width_p-1:2];
          end
          if (w_hs_c) begin
            w_held  <= 1'b1;
            wdata_q <= s_axil_wdata;
            wstrb_q <= s_axil_wstrb;
          end
          if (commit_c) begin
            w_state        <= W_RESP;
            s_axil_bvalid  <= 1'b1;
            s_axil_bresp   <= (SLVERR_EN && werr_c) ? RESP_SLVERR : RESP_OKAY;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
          end else begin
            s_axil_awready <= ~aw_have_c;
            s_axil_wready  <= ~w_have_c;
          end
        end
        W_RESP: begin
          if (s_axil_bready) begin
            w_state        <= W_ADDR_DATA;
            s_axil_bvalid  <= 1'b0;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            s_axil_awready <= 1'b1;
            s_axil_wready  <= 1'b1;
          end
        end
        default: w_state <= W_ADDR_DATA;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      csr_q <= '0;
    end else if (commit_c && (wdec_c == DEC_CSR)) begin
      for (int b = 0; b < 4; b++)
        if (wstrb_c[b]) csr_q[csr_idx(wword_c)][8*b +: 8] <= wdata_c[8*b +: 8];
    end
  end

  assign csr_o = csr_q;

  // Read decode samples pre-commit CSR values, so a colliding write is not visible yet.
  always_comb begin
    rword_c     = s_axil_araddr[addr_width_p-1:2];
    rdec_c      = decode(rword_c);
    ar_hs_c     = s_axil_arvalid & s_axil_arready;
    pl2ps_pop_c = ar_hs_c & (rdec_c == DEC_PL2PS_DATA);
    rdata_c     = '0;
    rerr_c      = 1'b0;
    case (rdec_c)
      DEC_CSR:         rdata_c = csr_q[csr_idx(rword_c)];
      DEC_PS2PL_FREE:  rdata_c = data_width_p'(fifo_els_p) - data_width_p'(ps2pl_count);
      DEC_PL2PS_COUNT: rdata_c = data_width_p'(pl2ps_count);
      DEC_PL2PS_DATA: begin
        if (pl2ps_empty) rerr_c  = 1'b1;
        else             rdata_c = pl2ps_head;
      end
      DEC_NONE:        rerr_c = 1'b1;
      default:         rdata_c = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state        <= R_ADDR;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_ADDR: begin
          s_axil_arready <= 1'b1;
          if (ar_hs_c) begin
            r_state        <= R_DATA;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b1;
            s_axil_rdata   <= rdata_c;
            s_axil_rresp   <= (SLVERR_EN && rerr_c) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        R_DATA: begin
          if (s_axil_rready) begin
            r_state        <= R_ADDR;
            s_axil_rvalid  <= 1'b0;
            s_axil_arready <= 1'b1;
          end
        end
        default: r_state <= R_ADDR;
      endcase
    end
  end

  zynq_axil_fifo_shell_fifo #(.els_p(fifo_els_p), .width_p(data_width_p)) u_ps2pl (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (ps2pl_push_c),
    .pop     (ps2pl_yumi_i),
    .wdata   (wdata_c),
    .head    (ps2pl_data_o),
    .count   (ps2pl_count),
    .full    (ps2pl_full),
    .empty   (ps2pl_empty)
  );

  zynq_axil_fifo_shell_fifo #(.els_p(fifo_els_p), .width_p(data_width_p)) u_pl2ps (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (pl2ps_v_i),
    .pop     (pl2ps_pop_c),
    .wdata   (pl2ps_data_i),
    .head    (pl2ps_head),
    .count   (pl2ps_count),
    .full    (pl2ps_full),
    .empty   (pl2ps_empty)
  );

  assign ps2pl_v_o   = ~ps2pl_empty;
  assign ready_and_o = ~pl2ps_full;

endmodule

// File: tb/tb_zynq_axil_fifo_shell.sv
// Randomized bench for zynq_axil_fifo_shell against a queue/array reference model.
// Honours ZYNQ_AXIL_FIFO_SHELL_SLVERR_EN when computing expected responses.
module tb_zynq_axil_fifo_shell;

`ifdef ZYNQ_AXIL_FIFO_SHELL_SLVERR_EN
  localparam bit slverr_en = 1'b1;
`else
  localparam bit slverr_en = 1'b0;
`endif
  localparam int depth = 8;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [9:0]   s_axil_awaddr = '0;
  logic [2:0]   s_axil_awprot = '0;
  logic         s_axil_awvalid = 1'b0;
  logic         s_axil_awready;
  logic [31:0]  s_axil_wdata = '0;
  logic [3:0]   s_axil_wstrb = '0;
  logic         s_axil_wvalid = 1'b0;
  logic         s_axil_wready;
  logic [1:0]   s_axil_bresp;
  logic         s_axil_bvalid;
  logic         s_axil_bready = 1'b0;
  logic [9:0]   s_axil_araddr = '0;
  logic [2:0]   s_axil_arprot = '0;
  logic         s_axil_arvalid = 1'b0;
  logic         s_axil_arready;
  logic [31:0]  s_axil_rdata;
  logic [1:0]   s_axil_rresp;
  logic         s_axil_rvalid;
  logic         s_axil_rready = 1'b0;
  logic [127:0] csr_o;
  logic [31:0]  ps2pl_data_o;
  logic         ps2pl_v_o;
  logic         ps2pl_yumi_i = 1'b0;
  logic [31:0]  pl2ps_data_i = '0;
  logic         pl2ps_v_i = 1'b0;
  logic         ready_and_o;

  zynq_axil_fifo_shell dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .csr_o(csr_o),
    .ps2pl_data_o(ps2pl_data_o), .ps2pl_v_o(ps2pl_v_o), .ps2pl_yumi_i(ps2pl_yumi_i),
    .pl2ps_data_i(pl2ps_data_i), .pl2ps_v_i(pl2ps_v_i), .ready_and_o(ready_and_o)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] m_csr [4];
  logic [31:0] m_ps2pl [$];
  logic [31:0] m_pl2ps [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] exp_resp(input bit err);
    return (slverr_en && err) ? 32'd2 : 32'd0;
  endfunction

  // aw_delay > 0: W leads AW by that many cycles; < 0: AW leads W. b_delay < 0: leave B pending.
  task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_delay, input int b_delay, output logic [1:0] r);
    bit aw_done, w_done, hs_aw, hs_w, hs_b;
    aw_done = 0; w_done = 0; hs_b = 0; r = 2'b11;
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    for (int cyc = 0; cyc < 50 && !(aw_done && w_done); cyc++) begin
      s_axil_awvalid = !aw_done && (cyc >= aw_delay);
      s_axil_wvalid  = !w_done && (cyc >= -aw_delay);
      if (w_done && !aw_done) chk("wready_low_while_held", 32'(s_axil_wready), 0);
      if (aw_done && !w_done) chk("awready_low_while_held", 32'(s_axil_awready), 0);
      hs_aw = s_axil_awvalid && s_axil_awready;
      hs_w  = s_axil_wvalid && s_axil_wready;
      @(negedge aclk);
      aw_done |= hs_aw; w_done |= hs_w;
    end
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    if (!(aw_done && w_done)) begin chk("aw_w_timeout", 0, 1); return; end
    chk("bvalid_rise", 32'(s_axil_bvalid), 1);
    if (b_delay < 0) return;
    for (int i = 0; i < b_delay; i++) begin
      @(negedge aclk);
      chk("bvalid_hold", 32'(s_axil_bvalid), 1);
      chk("readies_low_in_resp", 32'({s_axil_awready, s_axil_wready}), 0);
    end
    s_axil_bready = 1;
    for (int cyc = 0; cyc < 50 && !hs_b; cyc++) begin
      hs_b = s_axil_bvalid;
      r = s_axil_bresp;
      @(negedge aclk);
    end
    s_axil_bready = 0;
    if (!hs_b) chk("b_timeout", 0, 1);
  endtask

  task automatic axi_read_finish(input int r_delay, output logic [31:0] d, output logic [1:0] r);
    bit hs;
    hs = 0;
    chk("r_latency", 32'(s_axil_rvalid), 1);
    d = s_axil_rdata; r = s_axil_rresp;
    repeat (r_delay) @(negedge aclk);
    if (r_delay > 0) chk("rdata_stable", s_axil_rdata, d);
    s_axil_rready = 1;
    for (int cyc = 0; cyc < 50 && !hs; cyc++) begin
      hs = s_axil_rvalid;
      @(negedge aclk);
    end
    s_axil_rready = 0;
    if (!hs) chk("r_timeout", 0, 1);
  endtask

  task automatic axi_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] r);
    bit hs;
    hs = 0; d = '0; r = 2'b11;
    s_axil_araddr = a; s_axil_arvalid = 1;
    for (int cyc = 0; cyc < 50 && !hs; cyc++) begin
      hs = s_axil_arready;
      @(negedge aclk);
    end
    s_axil_arvalid = 0;
    if (!hs) begin chk("ar_timeout", 0, 1); return; end
    axi_read_finish($urandom_range(0, 2), d, r);
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] a, input logic [31:0] exp_d, input bit err);
    logic [31:0] d; logic [1:0] r;
    axi_read(a, d, r);
    chk(tag, d, exp_d);
    chk({tag, "_resp"}, 32'(r), exp_resp(err));
  endtask

  task automatic csr_wr(input int i, input logic [31:0] d, input logic [3:0] s, input int awd, input int bd);
    logic [1:0] r;
    axi_write(10'(i * 4), d, s, awd, bd, r);
    for (int b = 0; b < 4; b++) if (s[b]) m_csr[i][8*b +: 8] = d[8*b +: 8];
    chk("csr_wr_resp", 32'(r), exp_resp(0));
  endtask

  task automatic ps2pl_wr(input logic [31:0] d);
    logic [1:0] r; bit full;
    full = (m_ps2pl.size() >= depth);
    axi_write(10'h100, d, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2, $urandom_range(0, 2), r);
    if (!full) m_ps2pl.push_back(d);
    chk("ps2pl_wr_resp", 32'(r), exp_resp(full));
  endtask

  task automatic bad_wr(input logic [9:0] a, input bit err);
    logic [1:0] r;
    axi_write(a, $urandom, 4'hF, 0, 0, r);
    chk("bad_wr_resp", 32'(r), exp_resp(err));
  endtask

  task automatic pl_push(input logic [31:0] d);
    chk("pl_ready", 32'(ready_and_o), 32'(m_pl2ps.size() < depth));
    pl2ps_v_i = 1; pl2ps_data_i = d;
    if (m_pl2ps.size() < depth) m_pl2ps.push_back(d);
    @(negedge aclk);
    pl2ps_v_i = 0;
  endtask

  task automatic pl2ps_rd();
    logic [31:0] e; bit empty;
    empty = (m_pl2ps.size() == 0);
    e = empty ? 32'd0 : m_pl2ps.pop_front();
    rd_chk("pl2ps_rd", 10'h108, e, empty);
  endtask

  task automatic ps2pl_pop();
    chk("ps2pl_v", 32'(ps2pl_v_o), 32'(m_ps2pl.size() != 0));
    if (m_ps2pl.size() != 0) begin
      chk("ps2pl_data", ps2pl_data_o, m_ps2pl.pop_front());
      ps2pl_yumi_i = 1;
      @(negedge aclk);
      ps2pl_yumi_i = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, e; logic [1:0] r;
    logic [9:0] unmapped [4];
    unmapped = '{10'h010, 10'h110, 10'h200, 10'h3FC};
    for (int i = 0; i < 4; i++) m_csr[i] = '0;

    repeat (3) @(negedge aclk);
    aresetn = 1;
    #1;
    chk("rst_awready", 32'(s_axil_awready), 0);
    chk("rst_wready", 32'(s_axil_wready), 0);
    chk("rst_arready", 32'(s_axil_arready), 0);
    chk("rst_bvalid", 32'(s_axil_bvalid), 0);
    chk("rst_rvalid", 32'(s_axil_rvalid), 0);
    chk("rst_rdata", s_axil_rdata, 0);
    chk("rst_resps", 32'({s_axil_bresp, s_axil_rresp}), 0);
    chk("rst_csr_lo", csr_o[63:0] == 64'd0, 1);
    chk("rst_csr_hi", csr_o[127:64] == 64'd0, 1);
    chk("rst_ps2pl_v", 32'(ps2pl_v_o), 0);
    chk("rst_ready_and", 32'(ready_and_o), 1);
    @(negedge aclk);
    chk("post_rst_readies", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 3'b111);

    // Byte-strobed CSR write
    csr_wr(1, 32'hDEADBEEF, 4'b0011, 0, 0);
    rd_chk("csr1_strb", 10'h004, 32'h0000BEEF, 0);
    chk("csr_o_word1", csr_o[63:32], 32'h0000BEEF);

    // W one cycle ahead of AW, B back-pressured for 5 cycles
    csr_wr(2, 32'h12345678, 4'hF, 1, 5);
    chk("csr_o_word2", csr_o[95:64], 32'h12345678);
    rd_chk("csr2_rd", 10'h008, m_csr[2], 0);
    chk("readies_back", 32'({s_axil_awready, s_axil_wready}), 2'b11);

    // PS->PL overflow then ordered drain
    for (int i = 0; i < 9; i++) ps2pl_wr(32'hA000_0000 + 32'(i));
    rd_chk("free_full", 10'h104, 0, 0);
    chk("ps2pl_head_word0", ps2pl_data_o, 32'hA000_0000);
    for (int i = 0; i < 8; i++) ps2pl_pop();
    chk("ps2pl_drained", 32'(ps2pl_v_o), 0);
    rd_chk("free_empty", 10'h104, depth, 0);

    // PL->PS ordered pops, then empty read
    pl_push(32'h11); pl_push(32'h22); pl_push(32'h33);
    rd_chk("count3", 10'h10C, 3, 0);
    for (int i = 0; i < 4; i++) pl2ps_rd();
    rd_chk("count0", 10'h10C, 0, 0);

    // Full PL->PS FIFO: PL push and AXI pop in the same cycle
    for (int i = 0; i < depth; i++) pl_push(32'hC0 + 32'(i));
    chk("full_ready_and", 32'(ready_and_o), 0);
    pl_push(32'hBAD);
    chk("arready_idle", 32'(s_axil_arready), 1);
    s_axil_araddr = 10'h108; s_axil_arvalid = 1;
    pl2ps_v_i = 1; pl2ps_data_i = 32'hAB;
    @(negedge aclk);
    s_axil_arvalid = 0; pl2ps_v_i = 0;
    e = m_pl2ps.pop_front();
    m_pl2ps.push_back(32'hAB);
    axi_read_finish(1, d, r);
    chk("simul_pop_data", d, e);
    chk("simul_ready_and", 32'(ready_and_o), 0);
    rd_chk("simul_count", 10'h10C, depth, 0);
    for (int i = 0; i < depth + 1; i++) pl2ps_rd();

    // Randomized mix against the model
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1: csr_wr($urandom_range(0, 3), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 4) - 2, $urandom_range(0, 3));
        2:    begin int i = $urandom_range(0, 3); rd_chk("rand_csr", 10'(i * 4), m_csr[i], 0); end
        3:    ps2pl_wr($urandom);
        4:    ps2pl_pop();
        5:    pl_push($urandom);
        6:    pl2ps_rd();
        7:    rd_chk("rand_free", 10'h104, 32'(depth - m_ps2pl.size()), 0);
        8:    rd_chk("rand_count", 10'h10C, 32'(m_pl2ps.size()), 0);
        default: begin
          case ($urandom_range(0, 3))
            0: bad_wr(unmapped[$urandom_range(0, 3)], 1);
            1: bad_wr($urandom_range(0, 1) ? 10'h104 : 10'h10C, 1);
            2: bad_wr(10'h108, 0);
            default: rd_chk("unmapped_rd", unmapped[$urandom_range(0, 3)], 0, 1);
          endcase
        end
      endcase
    end
    for (int i = 0; i < 4; i++) rd_chk("final_csr", 10'(i * 4), m_csr[i], 0);

    // Reset while the write response is pending
    while (m_ps2pl.size() < 2) ps2pl_wr($urandom);
    if (m_pl2ps.size() < 2) begin pl_push($urandom); pl_push($urandom); end
    axi_write(10'h000, 32'hFFFF_FFFF, 4'hF, 0, -1, r);
    @(negedge aclk);
    aresetn = 0;
    #1;
    chk("rst_mid_bvalid", 32'(s_axil_bvalid), 0);
    chk("rst_mid_ps2pl_v", 32'(ps2pl_v_o), 0);
    chk("rst_mid_ready_and", 32'(ready_and_o), 1);
    chk("rst_mid_csr", csr_o == 128'd0, 1);
    for (int i = 0; i < 4; i++) m_csr[i] = '0;
    m_ps2pl.delete(); m_pl2ps.delete();
    @(negedge aclk);
    aresetn = 1;
    repeat (2) @(negedge aclk);
    for (int i = 0; i < 4; i++) rd_chk("post_rst_csr", 10'(i * 4), 0, 0);
    rd_chk("post_rst_free", 10'h104, depth, 0);
    rd_chk("post_rst_count", 10'h10C, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
